// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: state encoding and datapath width shared by the AES request scheduler
package aes_sched_pkg;
  localparam int AES_W = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, RESP = 2'd3} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr_i
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);
  logic [IW-1:0] j;
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    vld_o = |req_i;
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/aes_req_sched.sv
// aes_req_sched: shares one AES-128 core between NREQ requesters with round-robin
// grant, core sequencing with timeout, and an ID-tagged valid/ready response.
module aes_req_sched
  import aes_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_vld,
  output logic [NREQ-1:0]       req_rdy,
  input  logic [NREQ*AES_W-1:0] req_data,
  input  logic [NREQ*AES_W-1:0] req_key,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [AES_W-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  aes_rst,
  output logic [AES_W-1:0]      aes_din,
  output logic [AES_W-1:0]      aes_key,
  input  logic [AES_W-1:0]      aes_dout,
  input  logic                  aes_dvld,
  output logic                  busy
);
  localparam int AW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  logic [AW-1:0] rr_q, rr_d, idx;
  logic [IDW-1:0] id_q, id_d, rsp_id_q, rsp_id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] req_rdy_q, req_rdy_d, gnt;
  logic rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d, aes_rst_q, aes_rst_d, busy_q, busy_d;
  logic [AES_W-1:0] rsp_data_q, rsp_data_d, din_q, din_d, key_q, key_d;
  logic any, take, fin;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i(req_vld),
    .ptr_i(rr_q),
    .vld_o(any),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  assign take = (state_q == IDLE) && any;
  // aes_dvld is only ever looked at in RUN, so stale levels from a parked core are harmless.
  assign fin = (state_q == RUN) && (aes_dvld || cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      req_rdy_q <= '0;
      rsp_vld_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q <= '0;
      rsp_err_q <= 1'b0;
      aes_rst_q <= 1'b1;
      din_q <= '0;
      key_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      req_rdy_q <= req_rdy_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
      aes_rst_q <= aes_rst_d;
      din_q <= din_d;
      key_q <= key_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = any ? LOAD : IDLE;
      LOAD: state_d = RUN;
      RUN:  state_d = fin ? RESP : RUN;
      RESP: state_d = rsp_rdy ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_rdy_d = take ? gnt : '0;
    rr_d = take ? AW'((int'(idx) + 1) % NREQ) : rr_q;
    id_d = take ? IDW'(idx) : id_q;
    din_d = take ? req_data[int'(idx)*AES_W +: AES_W] : din_q;
    key_d = take ? req_key[int'(idx)*AES_W +: AES_W] : key_q;
    cnt_d = (state_q == RUN) ? cnt_q + CW'(1) : '0;
    rsp_vld_d = fin ? 1'b1 : (state_q == RESP && rsp_rdy) ? 1'b0 : rsp_vld_q;
    rsp_data_d = fin ? (aes_dvld ? aes_dout : '0) : rsp_data_q;
    rsp_err_d = fin ? !aes_dvld : rsp_err_q;
    rsp_id_d = fin ? id_q : rsp_id_q;
    aes_rst_d = state_d != RUN;
    busy_d = state_d != IDLE;
  end
  assign req_rdy = req_rdy_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id = rsp_id_q;
  assign rsp_err = rsp_err_q;
  assign aes_rst = aes_rst_q;
  assign aes_din = din_q;
  assign aes_key = key_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_aes_req_sched.sv
// tb_aes_req_sched: directed bench with a behavioural AES core stand-in (fixed
// latency, optional never-valid and sticky-valid modes).
module tb_aes_req_sched;
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req_vld = '0;
  logic [3:0] req_rdy;
  logic [511:0] req_data = '0;
  logic [511:0] req_key = '0;
  logic rsp_vld, rsp_err, aes_rst, aes_dvld, busy;
  logic rsp_rdy = 1'b0;
  logic [127:0] rsp_data, aes_din, aes_key, aes_dout, m_last, held;
  logic [1:0] rsp_id;
  logic [2:0] m_cnt;
  logic never = 1'b0;
  logic sticky = 1'b0;
  logic [3:0] oh;
  int checks = 0;
  int errors = 0;
  int n;
  int g;
  always #5 clk = ~clk;
  aes_req_sched #(.NREQ(4), .IDW(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_data(req_data), .req_key(req_key),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .aes_rst(aes_rst), .aes_din(aes_din), .aes_key(aes_key), .aes_dout(aes_dout), .aes_dvld(aes_dvld),
    .busy(busy)
  );
  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
    return (d == C1P && k == C1K) ? C1C : d ^ k;
  endfunction
  function automatic logic [127:0] dat(input int i);
    return {4{32'hA500_0000 | 32'(i)}};
  endfunction
  function automatic logic [127:0] kee(input int i);
    return {4{32'h005A_0000 | 32'(i * 16)}};
  endfunction
  // Core stand-in: result 4 cycles into RUN; in sticky mode the old result
  // survives a parked core until a different plaintext is presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_dvld <= 1'b0;
      aes_dout <= '0;
      m_cnt <= '0;
      m_last <= '0;
    end else begin
      m_last <= aes_din;
      if (aes_rst) begin
        m_cnt <= '0;
        if (!sticky || aes_din != m_last) aes_dvld <= 1'b0;
      end else if (!never && !aes_dvld) begin
        if (m_cnt == 3'd3) begin
          aes_dvld <= 1'b1;
          aes_dout <= cipher(aes_din, aes_key);
        end else m_cnt <= m_cnt + 3'd1;
      end
    end
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_rsp(input string tag);
    int k = 0;
    while (rsp_vld !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk(tag, rsp_vld, 1);
  endtask
  task automatic wait_rdy(input string tag);
    int k = 0;
    while (req_rdy === 4'b0 && k < 40) begin
      step();
      k++;
    end
    chk(tag, {124'b0, req_rdy === 4'b0}, 0);
  endtask
  initial begin
    step();
    step();
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_aes_rst", aes_rst, 1);
    chk("rst_aes_din", aes_din, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    // FIPS-197 C.1 through requester 0
    req_data[127:0] = C1P;
    req_key[127:0] = C1K;
    req_vld = 4'b0001;
    step();
    chk("c1_req_rdy", req_rdy, 4'b0001);
    chk("c1_load_aes_rst", aes_rst, 1);
    chk("c1_aes_din", aes_din, C1P);
    chk("c1_aes_key", aes_key, C1K);
    chk("c1_busy", busy, 1);
    req_vld = 4'b0000;
    step();
    chk("c1_run_aes_rst", aes_rst, 0);
    chk("c1_rdy_drop", req_rdy, 0);
    n = 0;
    while (aes_dvld !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("c1_dvld_seen", aes_dvld, 1);
    chk("c1_no_early_rsp", rsp_vld, 0);
    step();
    chk("c1_rsp_vld", rsp_vld, 1);
    chk("c1_rsp_data", rsp_data, C1C);
    chk("c1_rsp_id", rsp_id, 0);
    chk("c1_rsp_err", rsp_err, 0);
    chk("c1_resp_aes_rst", aes_rst, 1);
    rsp_rdy = 1'b1;
    step();
    chk("c1_rsp_drop", rsp_vld, 0);
    chk("c1_idle", busy, 0);
    rsp_rdy = 1'b0;
    // async reset in the middle of RUN
    req_data[383:256] = dat(2);
    req_key[383:256] = kee(2);
    req_vld = 4'b0100;
    step();
    chk("ar_req_rdy", req_rdy, 4'b0100);
    req_vld = 4'b0000;
    step();
    step();
    chk("ar_run_aes_rst", aes_rst, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_aes_rst", aes_rst, 1);
    chk("ar_busy", busy, 0);
    chk("ar_rsp_data", rsp_data, 0);
    chk("ar_rsp_vld", rsp_vld, 0);
    chk("ar_aes_din", aes_din, 0);
    chk("ar_aes_key", aes_key, 0);
    chk("ar_req_rdy0", req_rdy, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("ar_no_rsp", rsp_vld, 0);
    end
    chk("ar_idle", busy, 0);
    // round robin with all four requesting
    for (int i = 0; i < 4; i++) begin
      req_data[128*i +: 128] = dat(i);
      req_key[128*i +: 128] = kee(i);
    end
    req_vld = 4'b1111;
    rsp_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      oh = 4'b0001 << g;
      wait_rdy("rr_wait_rdy");
      chk("rr_onehot", req_rdy, oh);
      chk("rr_aes_din", aes_din, dat(g));
      if (k == 4) req_vld = 4'b0000;
      step();
      chk("rr_pulse", req_rdy, 0);
      wait_rsp("rr_wait_rsp");
      chk("rr_rsp_id", rsp_id, g);
      chk("rr_rsp_data", rsp_data, dat(g) ^ kee(g));
      step();
    end
    step();
    chk("rr_idle", busy, 0);
    // response backpressure, requester 3 waiting meanwhile
    rsp_rdy = 1'b0;
    req_vld = 4'b1010;
    wait_rdy("bp_wait_rdy");
    chk("bp_grant1", req_rdy, 4'b0010);
    req_vld = 4'b1000;
    wait_rsp("bp_wait_rsp");
    chk("bp_rsp_id", rsp_id, 1);
    chk("bp_rsp_data", rsp_data, dat(1) ^ kee(1));
    held = rsp_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_vld", rsp_vld, 1);
      chk("bp_hold_data", rsp_data, held);
      chk("bp_hold_id", rsp_id, 1);
      chk("bp_no_grant", req_rdy, 0);
    end
    rsp_rdy = 1'b1;
    step();
    chk("bp_rsp_drop", rsp_vld, 0);
    chk("bp_idle", busy, 0);
    chk("bp_no_grant_hs", req_rdy, 0);
    step();
    chk("bp_next_grant", req_rdy, 4'b1000);
    req_vld = 4'b0000;
    wait_rsp("bp_wait_rsp3");
    chk("bp_rsp_id3", rsp_id, 3);
    step();
    // timeout: core never answers
    never = 1'b1;
    rsp_rdy = 1'b0;
    req_vld = 4'b0001;
    step();
    chk("to_grant", req_rdy, 4'b0001);
    req_vld = 4'b0000;
    step();
    chk("to_run_entry", aes_rst, 0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("to_not_yet", rsp_vld, 0);
    end
    step();
    chk("to_rsp_vld", rsp_vld, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_data", rsp_data, 0);
    chk("to_rsp_id", rsp_id, 0);
    rsp_rdy = 1'b1;
    step();
    chk("to_rsp_drop", rsp_vld, 0);
    chk("to_idle", busy, 0);
    never = 1'b0;
    // sticky dvld from the previous result must not be taken as the next one
    sticky = 1'b1;
    rsp_rdy = 1'b0;
    req_vld = 4'b0010;
    wait_rdy("st_wait_rdy");
    chk("st_grant_a", req_rdy, 4'b0010);
    req_vld = 4'b0000;
    wait_rsp("st_wait_rsp_a");
    chk("st_rsp_a", rsp_data, dat(1) ^ kee(1));
    req_data[255:128] = dat(9);
    req_key[255:128] = kee(9);
    req_vld = 4'b0010;
    rsp_rdy = 1'b1;
    step();
    chk("st_idle", busy, 0);
    step();
    chk("st_grant_b", req_rdy, 4'b0010);
    req_vld = 4'b0000;
    n = 0;
    while (rsp_vld !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("st_latency", n, 6);
    chk("st_rsp_b", rsp_data, dat(9) ^ kee(9));
    chk("st_rsp_id", rsp_id, 1);
    chk("st_rsp_err", rsp_err, 0);
    step();
    chk("st_done", rsp_vld, 0);
    sticky = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_req_sched.md
Name: aes_req_sched

Overview:
- Shares one AES-128 encryption core (interface: clk, rst, d_in, key_in, d_out, d_vld) between NREQ requesters.
- Arbitrates round-robin and captures the winner's plaintext and key.
- Sequences the core: restart pulse, hold inputs, wait for d_vld, with timeout.
- Returns the ciphertext tagged with the requester ID through a valid/ready response port. Sits between host-side request queues and the single AES datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 64, max cycles in RUN waiting for aes_dvld before aborting (>= 2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_vld  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  one-hot accept pulse; the request transfers when req_vld[i] and req_rdy[i] are both high.
- req_data  in  NREQ*128  plaintexts; requester i occupies bits [128*i+127:128*i].
- req_key  in  NREQ*128  keys, same packing as req_data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response consumer ready.
- rsp_data  out  128  ciphertext; 0 on error.
- rsp_id  out  IDW  index of the served requester.
- rsp_err  out  1  set when the core timed out.
- aes_rst  out  1  active-high restart to the core.
- aes_din  out  128  plaintext to the core.
- aes_key  out  128  key to the core.
- aes_dout  in  128  core ciphertext.
- aes_dvld  in  1  core result valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, rr_ptr=0, req_rdy=0, rsp_vld=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - aes_rst=1 (core held in reset), aes_din=0, aes_key=0, busy=0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - aes_rst=1.
  - If any req_vld is high, grant g = the first index i at or after rr_ptr (cyclic) with req_vld[i]=1.
  - Accept: req_rdy[g]=1 for exactly this cycle. Capture req_data[g] -> aes_din, req_key[g] -> aes_key, g -> id_reg. Set rr_ptr = (g+1) mod NREQ. Go to LOAD.
  - With no request, stay in IDLE with req_rdy=0.
- LOAD: one cycle with aes_rst=1 and aes_din/aes_key stable. Clear the counter. Go to RUN.
- RUN:
  - aes_rst=0; aes_din/aes_key held constant.
  - The counter increments every cycle.
  - If aes_dvld=1: rsp_data=aes_dout, rsp_err=0, rsp_id=id_reg, rsp_vld=1, go to RESP.
  - Else if counter reaches TIMEOUT-1: rsp_data=0, rsp_err=1, rsp_vld=1, go to RESP. A dvld in the same cycle as expiry takes priority over the timeout.
- RESP:
  - aes_rst=1 (parks the core, so a sticky d_vld drops).
  - rsp_vld, rsp_data, rsp_id and rsp_err stay stable until rsp_rdy=1.
  - On the handshake cycle: rsp_vld=0 next cycle, go to IDLE. No new grant is issued in the handshake cycle itself.
- aes_dvld is ignored outside RUN; a stale high level in IDLE or LOAD is never sampled.
- Latency:
  - Accept at cycle T; LOAD at T+1; RUN from T+2.
  - Core dvld at cycle R produces rsp_vld at R+1.
  - Minimum gap between consecutive accepts is 4 cycles plus response backpressure.
- Fairness:
  - A continuously requesting requester is served within NREQ grants.
  - rr_ptr advances only on an accept.
- Requesters must hold req_vld and the data/key stable until their req_rdy pulse. Dropping req_vld before the grant is legal; that requester is simply not chosen.
- Reset mid-operation aborts the transaction. No response is produced and the captured request is lost.

Decomposition:
- Package aes_sched_pkg holds:
  - the state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, RESP=2'd3);
  - the AES width constant (128).
- Sub-module rr_arbiter(NREQ): combinational grant from req_vld and rr_ptr, outputting a one-hot grant and an encoded index.
- The FSM, counter and datapath registers stay in aes_req_sched.

Test Plan:
- Single request, FIPS-197 C.1 vector: req 0 with key 000102030405060708090a0b0c0d0e0f and data 00112233445566778899aabbccddeeff -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, rsp_err=0, rsp_vld exactly 1 cycle after aes_dvld.
- All four req_vld held high with distinct data, rsp_rdy=1 -> grant order 0,1,2,3,0. Each req_rdy is a single-cycle one-hot pulse, and rsp_id follows the same order.
- Backpressure: rsp_rdy=0 for 10 cycles after rsp_vld -> rsp_vld, rsp_data and rsp_id stay stable, and req_rdy stays 0 throughout. After rsp_rdy=1, the next grant occurs 1 cycle after the handshake.
- Timeout with TIMEOUT=8: core model never asserts dvld -> rsp_vld rises 8 cycles after RUN entry with rsp_err=1 and rsp_data=0, then the FSM returns to IDLE.
- Sticky dvld: core model holds dvld=1 after its result -> the next request still waits for the new result (LOAD restarts the core), and the old ciphertext is never returned.
- Async reset asserted mid-RUN -> all outputs take their reset values immediately with aes_rst=1. After release, the FSM is in IDLE with rr_ptr=0 and no spurious rsp_vld.
